// File: rtl/bram_dump_reader_pkg.sv
// Shared definitions for the bram32 readback engine: FSM state encodings and address stride.
package bram_dump_reader_pkg;

    typedef enum logic [2:0] {
        DUMP_IDLE = 3'd0,
        DUMP_ADDR = 3'd1,
        DUMP_WAIT = 3'd2,
        DUMP_SEND = 3'd3,
        DUMP_CSUM = 3'd4,
        DUMP_FIN  = 3'd5
    } dump_state_e;

    localparam int ADDR_STRIDE = 4;

endpackage

// File: rtl/bram_dump_reader.sv
// Reads word_count words from the bram32 debug port and streams them on a valid/ready interface.
// Optional trailing XOR checksum beat when DUMP_CHECKSUM_EN is defined.
module bram_dump_reader
    import bram_dump_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  word_count,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] debug_addr,
    input  logic [DATA_WIDTH-1:0] debug_data,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready
);

    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO   = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO  = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(ADDR_STRIDE);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO  = {DATA_WIDTH{1'b0}};

    dump_state_e             state_r, state_nxt;
    logic [ADDR_WIDTH-1:0]   cur_addr_r, cur_addr_nxt;
    logic [CNT_WIDTH-1:0]    remaining_r, remaining_nxt;
    logic                    busy_r, busy_nxt;
    logic                    done_r, done_nxt;
    logic [ADDR_WIDTH-1:0]   debug_addr_r, debug_addr_nxt;
    logic                    m_valid_r, m_valid_nxt;
    logic [DATA_WIDTH-1:0]   m_data_r, m_data_nxt;
    logic                    m_last_r, m_last_nxt;
    logic                    handshake_s;
    logic                    last_word_s;
    logic [ADDR_WIDTH-1:0]   aligned_base_s;
`ifdef DUMP_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]   csum_r, csum_nxt;
`endif

    assign handshake_s    = m_valid_r && m_ready;
    assign last_word_s    = (remaining_r == CNT_ONE);
    assign aligned_base_s = base_addr & ALIGN_MASK;

    // Next-state and next-output logic; debug_addr is loaded one state early so the
    // synchronous BRAM read completes during WAIT.
    always_comb begin
        state_nxt      = state_r;
        cur_addr_nxt   = cur_addr_r;
        remaining_nxt  = remaining_r;
        busy_nxt       = busy_r;
        done_nxt       = 1'b0;
        debug_addr_nxt = debug_addr_r;
        m_valid_nxt    = m_valid_r;
        m_data_nxt     = m_data_r;
        m_last_nxt     = m_last_r;
`ifdef DUMP_CHECKSUM_EN
        csum_nxt       = csum_r;
`endif
        case (state_r)
            DUMP_IDLE: begin
                if (start) begin
                    busy_nxt       = 1'b1;
                    cur_addr_nxt   = aligned_base_s;
                    debug_addr_nxt = aligned_base_s;
                    remaining_nxt  = word_count;
`ifdef DUMP_CHECKSUM_EN
                    csum_nxt       = DATA_ZERO;
`endif
                    if (word_count == CNT_ZERO) begin
`ifdef DUMP_CHECKSUM_EN
                        m_data_nxt  = DATA_ZERO;
                        m_valid_nxt = 1'b1;
                        m_last_nxt  = 1'b1;
                        state_nxt   = DUMP_CSUM;
`else
                        state_nxt   = DUMP_FIN;
`endif
                    end else begin
                        state_nxt = DUMP_ADDR;
                    end
                end else begin
                    state_nxt = DUMP_IDLE;
                end
            end
            DUMP_ADDR: begin
                debug_addr_nxt = cur_addr_r;
                state_nxt      = DUMP_WAIT;
            end
            DUMP_WAIT: begin
                m_data_nxt  = debug_data;
                m_valid_nxt = 1'b1;
`ifdef DUMP_CHECKSUM_EN
                m_last_nxt  = 1'b0;
`else
                m_last_nxt  = last_word_s;
`endif
                state_nxt   = DUMP_SEND;
            end
            DUMP_SEND: begin
                if (handshake_s) begin
                    m_valid_nxt    = 1'b0;
                    m_last_nxt     = 1'b0;
                    cur_addr_nxt   = cur_addr_r + ADDR_STEP;
                    debug_addr_nxt = cur_addr_r + ADDR_STEP;
                    remaining_nxt  = remaining_r - CNT_ONE;
`ifdef DUMP_CHECKSUM_EN
                    csum_nxt       = csum_r ^ m_data_r;
`endif
                    if (last_word_s) begin
`ifdef DUMP_CHECKSUM_EN
                        m_data_nxt  = csum_r ^ m_data_r;
                        m_valid_nxt = 1'b1;
                        m_last_nxt  = 1'b1;
                        state_nxt   = DUMP_CSUM;
`else
                        state_nxt   = DUMP_FIN;
`endif
                    end else begin
                        state_nxt = DUMP_ADDR;
                    end
                end else begin
                    state_nxt = DUMP_SEND;
                end
            end
            DUMP_CSUM: begin
                if (handshake_s) begin
                    m_valid_nxt = 1'b0;
                    m_last_nxt  = 1'b0;
                    state_nxt   = DUMP_FIN;
                end else begin
                    state_nxt = DUMP_CSUM;
                end
            end
            DUMP_FIN: begin
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = DUMP_IDLE;
            end
            default: begin
                busy_nxt    = 1'b0;
                m_valid_nxt = 1'b0;
                m_last_nxt  = 1'b0;
                state_nxt   = DUMP_IDLE;
            end
        endcase
    end

    // State and registered-output update; reset aborts any dump without a done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= DUMP_IDLE;
            cur_addr_r   <= ADDR_ZERO;
            remaining_r  <= CNT_ZERO;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            debug_addr_r <= ADDR_ZERO;
            m_valid_r    <= 1'b0;
            m_data_r     <= DATA_ZERO;
            m_last_r     <= 1'b0;
        end else begin
            state_r      <= state_nxt;
            cur_addr_r   <= cur_addr_nxt;
            remaining_r  <= remaining_nxt;
            busy_r       <= busy_nxt;
            done_r       <= done_nxt;
            debug_addr_r <= debug_addr_nxt;
            m_valid_r    <= m_valid_nxt;
            m_data_r     <= m_data_nxt;
            m_last_r     <= m_last_nxt;
        end
    end

`ifdef DUMP_CHECKSUM_EN
    // Running XOR of every handshaken data word, cleared on each accepted start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            csum_r <= DATA_ZERO;
        end else begin
            csum_r <= csum_nxt;
        end
    end
`endif

    assign busy       = busy_r;
    assign done       = done_r;
    assign debug_addr = debug_addr_r;
    assign m_valid    = m_valid_r;
    assign m_data     = m_data_r;
    assign m_last     = m_last_r;

endmodule
